// File: rtl/cond_flag_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit_if
// Description : Request/result handshake between the control unit and the
//               condition-flag unit.
//               Request : cond_valid/cond_ready with a 4-bit ARM cond field.
//               Result  : pass_valid/pass_ack with a 1-bit pass verdict.
//               master = control unit side, slave = cond_flag_unit side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_flag_unit_if;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       pass_valid;
  logic       pass;
  logic       pass_ack;

  modport master (
    output cond_valid,
    output cond,
    output pass_ack,
    input  cond_ready,
    input  pass_valid,
    input  pass
  );

  modport slave (
    input  cond_valid,
    input  cond,
    input  pass_ack,
    output cond_ready,
    output pass_valid,
    output pass
  );
endinterface
`default_nettype wire

// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : Consumer of the ALU condition codes. Latches NZCV into a
//               status register on flag_we, returns stored C as ALU Cin and
//               evaluates ARM condition fields, delivering the verdict through
//               a one-entry valid/ack output stage.
//               Optional macro FLAG_BYPASS_EN: forward incoming ALU flags to
//               a request accepted in the same cycle as flag_we.
// Ports       : clk, reset_n (sync, active-low)
//               flag_we, alu_n/z/c/v   - status register load
//               bus (slave)            - cond request / pass result handshake
//               flags {N,Z,C,V}, cin_out, fail_count (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter int         CNT_W      = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             flag_we,
  input  wire logic             alu_n,
  input  wire logic             alu_z,
  input  wire logic             alu_c,
  input  wire logic             alu_v,
  cond_flag_unit_if.slave       bus,
  output logic [3:0]            flags,
  output logic                  cin_out,
  output logic [CNT_W-1:0]      fail_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       flags_q, flags_d;
  logic             pass_valid_q, pass_valid_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;

  logic [3:0]       alu_flags;
  logic [3:0]       eval_flags;
  logic             ready;
  logic             accept;

  // ARM condition evaluation against {N,Z,C,V}.
  function automatic logic eval_cond(input logic [3:0] cf, input logic [3:0] f);
    logic fn, fz, fc, fv;
    logic r;
    fn = f[3];
    fz = f[2];
    fc = f[1];
    fv = f[0];
    case (cf)
      4'h0:    r = fz;
      4'h1:    r = !fz;
      4'h2:    r = fc;
      4'h3:    r = !fc;
      4'h4:    r = fn;
      4'h5:    r = !fn;
      4'h6:    r = fv;
      4'h7:    r = !fv;
      4'h8:    r = fc & !fz;
      4'h9:    r = !fc | fz;
      4'hA:    r = (fn == fv);
      4'hB:    r = (fn != fv);
      4'hC:    r = !fz & (fn == fv);
      4'hD:    r = fz | (fn != fv);
      4'hE:    r = 1'b1;
      default: r = 1'b0;  // NV is reserved: always squash
    endcase
    return r;
  endfunction

  assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

  // One-entry output stage: a slot frees up in the same cycle it is acked.
  assign ready  = !pass_valid_q | bus.pass_ack;
  assign accept = bus.cond_valid & ready;

`ifdef FLAG_BYPASS_EN
  assign eval_flags = flag_we ? alu_flags : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  always_comb begin
    flags_d      = flags_q;
    pass_valid_d = pass_valid_q;
    pass_d       = pass_q;
    fail_d       = fail_q;

    if (flag_we) begin
      flags_d = alu_flags;
    end

    if (accept) begin
      pass_valid_d = 1'b1;
      pass_d       = eval_cond(bus.cond, eval_flags);
    end else if (bus.pass_ack) begin
      pass_valid_d = 1'b0;
    end

    // Count squashes only when they are actually delivered to the consumer.
    if (pass_valid_q && bus.pass_ack && !pass_q && (fail_q != CNT_MAX)) begin
      fail_d = fail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q      <= FLAG_RESET;
      pass_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= '0;
    end else begin
      flags_q      <= flags_d;
      pass_valid_q <= pass_valid_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.cond_ready = ready;
  assign bus.pass_valid = pass_valid_q;
  assign bus.pass       = pass_q;
  assign flags          = flags_q;
  assign cin_out        = flags_q[1];
  assign fail_count     = fail_q;

endmodule
`default_nettype wire
